// File: rtl/delta_enc_if.sv
// Valid/ready bus for the first-difference encoder: sample input, difference output, sample counter.
interface delta_enc_if #(
    parameter int LEN   = 8,
    parameter int CNT_W = 16
);
    logic [LEN-1:0]   in_data;
    logic             in_valid;
    logic             in_ready;
    logic             clr;
    logic [LEN-1:0]   out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] sample_cnt;

    modport master (
        output in_data, in_valid, clr, out_ready,
        input  in_ready, out_data, out_valid, sample_cnt
    );

    modport slave (
        input  in_data, in_valid, clr, out_ready,
        output in_ready, out_data, out_valid, sample_cnt
    );
endinterface

// File: rtl/delta_enc.sv
// Streaming first-difference encoder d[n] = x[n] - x[n-1] mod 2^LEN,
// with a head/skid output buffer so in_ready never depends on out_ready.
module delta_enc #(
    parameter int LEN   = 8,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    delta_enc_if.slave  bus
);
    logic [LEN-1:0]   prev_q, prev_d;
    logic [LEN-1:0]   head_q, head_d;
    logic [LEN-1:0]   skid_q, skid_d;
    logic             head_valid_q, head_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             pop;
    logic [LEN-1:0]   pred;
    logic [LEN-1:0]   diff;

    assign bus.in_ready   = !skid_valid_q;
    assign bus.out_valid  = head_valid_q;
    assign bus.out_data   = head_q;
    assign bus.sample_cnt = cnt_q;

    // A clear on the accepting edge makes that sample difference against zero.
    always_comb begin
        accept = bus.in_valid && !skid_valid_q;
        pop    = head_valid_q && bus.out_ready;
        pred   = bus.clr ? '0 : prev_q;
        diff   = bus.in_data - pred;
    end

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (accept) begin
            prev_d = bus.in_data;
            cnt_d  = bus.clr ? {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (bus.clr) begin
            prev_d = '0;
            cnt_d  = '0;
        end
    end

    // Two-entry FIFO: the skid only ever holds the younger entry, so it drains into head first.
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (pop) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                head_valid_d = 1'b0;
            end
        end
        if (accept) begin
            if (!head_valid_q || pop) begin
                if (skid_valid_q) begin
                    skid_d       = diff;
                    skid_valid_d = 1'b1;
                end else begin
                    head_d       = diff;
                    head_valid_d = 1'b1;
                end
            end else begin
                skid_d       = diff;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            prev_q       <= prev_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule
